// File: rtl/mips_cpu_bus_bridge.sv
// Memory front-end for the MIPS core.
// It merges the instruction-fetch and data load/store request ports into one
// Avalon-MM style master, and it stalls the core until each access completes.
// Define MIPS_BUS_TIMEOUT_EN to enable the waitrequest watchdog and the sticky
// bus_error flag. When the macro is undefined, an access waits indefinitely for
// the slave.
module mips_cpu_bus_bridge #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned ARB_MODE       = 0,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  instr_req,
    input  logic [ADDR_W-1:0]     instr_address,
    output logic [DATA_W-1:0]     instr_readdata,
    output logic                  instr_valid,
    input  logic                  data_read,
    input  logic                  data_write,
    input  logic [ADDR_W-1:0]     data_address,
    input  logic [DATA_W/8-1:0]   data_byteenable,
    input  logic [DATA_W-1:0]     data_writedata,
    output logic [DATA_W-1:0]     data_readdata,
    output logic                  data_valid,
    output logic                  stall,
    output logic                  bus_error,
    output logic [ADDR_W-1:0]     avm_address,
    output logic                  avm_read,
    output logic                  avm_write,
    output logic [DATA_W-1:0]     avm_writedata,
    output logic [DATA_W/8-1:0]   avm_byteenable,
    input  logic                  avm_waitrequest,
    input  logic [DATA_W-1:0]     avm_readdata
);

    localparam logic [31:0] DEAD_WORD = 32'hDEADBEEF;

    if ((DATA_W % 8) != 0 || TIMEOUT_CYCLES == 0) begin : g_param_check
        $error("mips_cpu_bus_bridge: DATA_W must be a multiple of 8, TIMEOUT_CYCLES nonzero");
    end

    typedef enum logic [1:0] {IDLE, INSTR_ACC, DATA_ACC} state_t;

    state_t state, state_next;
    logic   grant_instr, grant_data, done, timeout_hit;
    logic   data_pending;
    logic   rr_last;  // 0: instruction port served last, 1: data port served last

    assign data_pending = data_read | data_write;

`ifdef MIPS_BUS_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] watchdog;

    // The abort fires on the edge that would record the TIMEOUT_CYCLES-th stalled cycle.
    assign timeout_hit = (state != IDLE) && avm_waitrequest &&
                         (watchdog == WD_W'(TIMEOUT_CYCLES - 1));

    // Watchdog counts stalled cycles in an access and restarts on every grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            watchdog <= '0;
        end else if (grant_instr || grant_data) begin
            watchdog <= '0;
        end else if (state != IDLE && avm_waitrequest) begin
            watchdog <= watchdog + 1'b1;
        end
    end

    // The error flag is sticky until reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus_error <= 1'b0;
        end else if (timeout_hit) begin
            bus_error <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign bus_error   = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Arbitration and access completion.
    always_comb begin
        state_next  = state;
        grant_instr = 1'b0;
        grant_data  = 1'b0;
        done        = 1'b0;
        unique case (state)
            IDLE: begin
                // Data wins unless round-robin says instruction's turn under contention.
                if (data_pending && (!instr_req || ARB_MODE == 0 || !rr_last)) begin
                    grant_data = 1'b1;
                    state_next = DATA_ACC;
                end else if (instr_req) begin
                    grant_instr = 1'b1;
                    state_next  = INSTR_ACC;
                end
            end
            INSTR_ACC, DATA_ACC: begin
                if (!avm_waitrequest || timeout_hit) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Bus master registers, read capture and completion pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            avm_address    <= '0;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            avm_writedata  <= '0;
            avm_byteenable <= '0;
            instr_readdata <= '0;
            data_readdata  <= '0;
            instr_valid    <= 1'b0;
            data_valid     <= 1'b0;
            rr_last        <= 1'b0;
        end else begin
            instr_valid <= 1'b0;
            data_valid  <= 1'b0;
            if (grant_instr) begin
                avm_address    <= instr_address;
                avm_byteenable <= '1;
                avm_writedata  <= '0;
                avm_read       <= 1'b1;
                avm_write      <= 1'b0;
                rr_last        <= 1'b0;
            end
            if (grant_data) begin
                avm_address    <= data_address;
                avm_byteenable <= data_byteenable;
                avm_writedata  <= data_writedata;
                // A simultaneous read and write is treated as a write.
                avm_read       <= ~data_write;
                avm_write      <= data_write;
                rr_last        <= 1'b1;
            end
            if (done) begin
                avm_read  <= 1'b0;
                avm_write <= 1'b0;
                if (state == INSTR_ACC) begin
                    instr_valid    <= 1'b1;
                    instr_readdata <= timeout_hit ? DATA_W'(DEAD_WORD) : avm_readdata;
                end else begin
                    data_valid <= 1'b1;
                    if (timeout_hit) begin
                        data_readdata <= DATA_W'(DEAD_WORD);
                    end else if (avm_read) begin
                        data_readdata <= avm_readdata;
                    end
                end
            end
        end
    end

    assign stall = (instr_req & ~instr_valid) | (data_pending & ~data_valid);

endmodule
